// File: rtl/pattern_tx.sv
// Serializes parallel pattern words MSB-first onto a single-bit stream, with a
// one-word holding buffer so consecutive words go out without idle cycles.
module pattern_tx #(
    parameter int unsigned DATA_W = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [DATA_W-1:0] data_in,
    input  logic [3:0]        len_in,
    input  logic              load,
    output logic              ready,
    output logic              x_out,
    output logic              x_valid,
    output logic              done
);

    localparam int unsigned CNT_W = $clog2(DATA_W + 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t              state, state_nxt;
    logic [DATA_W-1:0]   sh_word, sh_word_nxt;
    logic [CNT_W-1:0]    sh_cnt, sh_cnt_nxt;
    logic [DATA_W-1:0]   hold_word, hold_word_nxt;
    logic [CNT_W-1:0]    hold_len, hold_len_nxt;
    logic                ready_nxt, x_out_nxt, x_valid_nxt, done_nxt;

    logic [CNT_W-1:0]    in_len;
    logic [DATA_W-1:0]   in_word;
    logic                accept;
    logic [DATA_W-1:0]   src_word;
    logic [CNT_W-1:0]    src_len;

    // Normalize length and left-align the active bits so the next bit is always the MSB.
    always_comb begin
        in_len = CNT_W'(len_in);
        if (len_in == 4'd0 || 32'(len_in) > DATA_W) begin
            in_len = CNT_W'(DATA_W);
        end
        in_word = data_in << (CNT_W'(DATA_W) - in_len);
    end

    assign accept   = load & ready;
    // A full buffer (ready=0) always wins the launch slot; a new accept is only possible when it is empty.
    assign src_word = ready ? in_word : hold_word;
    assign src_len  = ready ? in_len  : hold_len;

    always_comb begin
        state_nxt     = state;
        sh_word_nxt   = sh_word;
        sh_cnt_nxt    = sh_cnt;
        hold_word_nxt = hold_word;
        hold_len_nxt  = hold_len;
        ready_nxt     = ready;
        x_out_nxt     = 1'b0;
        x_valid_nxt   = 1'b0;
        done_nxt      = 1'b0;

        if (state == SHIFT && sh_cnt != '0) begin
            x_out_nxt   = sh_word[DATA_W-1];
            x_valid_nxt = 1'b1;
            done_nxt    = (sh_cnt == CNT_W'(1));
            sh_word_nxt = sh_word << 1;
            sh_cnt_nxt  = sh_cnt - CNT_W'(1);
            if (accept) begin
                hold_word_nxt = in_word;
                hold_len_nxt  = in_len;
                ready_nxt     = 1'b0;
            end
        end else if (!ready || accept) begin
            // Shifter is free (idle, or its last bit ends now): launch buffered or incoming word.
            state_nxt     = SHIFT;
            x_out_nxt     = src_word[DATA_W-1];
            x_valid_nxt   = 1'b1;
            done_nxt      = (src_len == CNT_W'(1));
            sh_word_nxt   = src_word << 1;
            sh_cnt_nxt    = src_len - CNT_W'(1);
            hold_word_nxt = '0;
            hold_len_nxt  = '0;
            ready_nxt     = 1'b1;
        end else begin
            state_nxt   = IDLE;
            sh_word_nxt = '0;
            sh_cnt_nxt  = '0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            sh_word   <= '0;
            sh_cnt    <= '0;
            hold_word <= '0;
            hold_len  <= '0;
            ready     <= 1'b1;
            x_out     <= 1'b0;
            x_valid   <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_nxt;
            sh_word   <= sh_word_nxt;
            sh_cnt    <= sh_cnt_nxt;
            hold_word <= hold_word_nxt;
            hold_len  <= hold_len_nxt;
            ready     <= ready_nxt;
            x_out     <= x_out_nxt;
            x_valid   <= x_valid_nxt;
            done      <= done_nxt;
        end
    end

endmodule

// File: tb/tb_pattern_tx.sv
// Directed bench for pattern_tx: per-cycle vector table plus reset-abort and
// sequence-detector sequences.
module tb_pattern_tx;

    logic       clock;
    logic       reset;
    logic [7:0] data_in;
    logic [3:0] len_in;
    logic       load;
    logic       ready;
    logic       x_out;
    logic       x_valid;
    logic       done;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       ld;
        logic [7:0] d;
        logic [3:0] len;
        logic       xo;
        logic       xv;
        logic       dn;
        logic       rdy;
    } vec_t;

    vec_t vecs[$];

    pattern_tx #(.DATA_W(8)) dut (
        .clock   (clock),
        .reset   (reset),
        .data_in (data_in),
        .len_in  (len_in),
        .load    (load),
        .ready   (ready),
        .x_out   (x_out),
        .x_valid (x_valid),
        .done    (done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // "1011" overlapping detector fed by the serial stream
    logic [3:0] hist;
    logic       det;
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            hist <= 4'd0;
            det  <= 1'b0;
        end else if (x_valid) begin
            hist <= {hist[2:0], x_out};
            det  <= ({hist[2:0], x_out} == 4'b1011);
        end else begin
            det  <= 1'b0;
        end
    end

    function automatic void add(input logic ld, input logic [7:0] d, input logic [3:0] len,
                                input logic xo, input logic xv, input logic dn, input logic rdy);
        vec_t v;
        v.ld = ld; v.d = d; v.len = len; v.xo = xo; v.xv = xv; v.dn = dn; v.rdy = rdy;
        vecs.push_back(v);
    endfunction

    task automatic chk(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%b expected=%b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset = 1'b1; load = 1'b0; data_in = 8'h00; len_in = 4'd0;

        // B4, len 8: 1,0,1,1,0,1,0,0
        add(1, 8'hB4, 4'd8, 1, 1, 0, 1);
        add(0, 8'h00, 4'd0, 0, 1, 0, 1);
        add(0, 8'h00, 4'd0, 1, 1, 0, 1);
        add(0, 8'h00, 4'd0, 1, 1, 0, 1);
        add(0, 8'h00, 4'd0, 0, 1, 0, 1);
        add(0, 8'h00, 4'd0, 1, 1, 0, 1);
        add(0, 8'h00, 4'd0, 0, 1, 0, 1);
        add(0, 8'h00, 4'd0, 0, 1, 1, 1);
        add(0, 8'h00, 4'd0, 0, 0, 0, 1);
        // 05/3 then 03/2 buffered: 1,0,1,1,1 with no gap
        add(1, 8'h05, 4'd3, 1, 1, 0, 1);
        add(1, 8'h03, 4'd2, 0, 1, 0, 0);
        add(0, 8'h00, 4'd0, 1, 1, 1, 0);
        add(0, 8'h00, 4'd0, 1, 1, 0, 1);
        add(0, 8'h00, 4'd0, 1, 1, 1, 1);
        add(0, 8'h00, 4'd0, 0, 0, 0, 1);
        // 81 with len 0; len/data wiggle afterwards must not matter
        add(1, 8'h81, 4'd0, 1, 1, 0, 1);
        add(0, 8'h5A, 4'd3, 0, 1, 0, 1);
        add(0, 8'h5A, 4'd3, 0, 1, 0, 1);
        add(0, 8'h5A, 4'd1, 0, 1, 0, 1);
        add(0, 8'h5A, 4'd1, 0, 1, 0, 1);
        add(0, 8'h5A, 4'd2, 0, 1, 0, 1);
        add(0, 8'h5A, 4'd2, 0, 1, 0, 1);
        add(0, 8'h5A, 4'd2, 1, 1, 1, 1);
        add(0, 8'h00, 4'd0, 0, 0, 0, 1);
        // 81 with len 12 behaves as len 8
        add(1, 8'h81, 4'd12, 1, 1, 0, 1);
        add(0, 8'h00, 4'd0, 0, 1, 0, 1);
        add(0, 8'h00, 4'd0, 0, 1, 0, 1);
        add(0, 8'h00, 4'd0, 0, 1, 0, 1);
        add(0, 8'h00, 4'd0, 0, 1, 0, 1);
        add(0, 8'h00, 4'd0, 0, 1, 0, 1);
        add(0, 8'h00, 4'd0, 0, 1, 0, 1);
        add(0, 8'h00, 4'd0, 1, 1, 1, 1);
        add(0, 8'h00, 4'd0, 0, 0, 0, 1);
        // buffer full: FF loads ignored; stream 1111 then 01010000
        add(1, 8'h0F, 4'd4, 1, 1, 0, 1);
        add(1, 8'h50, 4'd8, 1, 1, 0, 0);
        add(1, 8'hFF, 4'd8, 1, 1, 0, 0);
        add(1, 8'hFF, 4'd8, 1, 1, 1, 0);
        add(0, 8'h00, 4'd0, 0, 1, 0, 1);
        add(0, 8'h00, 4'd0, 1, 1, 0, 1);
        add(0, 8'h00, 4'd0, 0, 1, 0, 1);
        add(0, 8'h00, 4'd0, 1, 1, 0, 1);
        add(0, 8'h00, 4'd0, 0, 1, 0, 1);
        add(0, 8'h00, 4'd0, 0, 1, 0, 1);
        add(0, 8'h00, 4'd0, 0, 1, 0, 1);
        add(0, 8'h00, 4'd0, 0, 1, 1, 1);
        add(0, 8'h00, 4'd0, 0, 0, 0, 1);
        // single-bit words, second accepted on the edge ending the first
        add(1, 8'h01, 4'd1, 1, 1, 1, 1);
        add(1, 8'h00, 4'd1, 0, 1, 1, 1);
        add(0, 8'h00, 4'd0, 0, 0, 0, 1);

        // asynchronous reset state before any clock edge
        #3;
        chk("rst_xv", x_valid, 1'b0);
        chk("rst_xo", x_out, 1'b0);
        chk("rst_dn", done, 1'b0);
        chk("rst_rdy", ready, 1'b1);
        step();
        step();
        reset = 1'b0;

        foreach (vecs[i]) begin
            load = vecs[i].ld; data_in = vecs[i].d; len_in = vecs[i].len;
            step();
            chk($sformatf("v%0d_xo", i), x_out, vecs[i].xo);
            chk($sformatf("v%0d_xv", i), x_valid, vecs[i].xv);
            chk($sformatf("v%0d_dn", i), done, vecs[i].dn);
            chk($sformatf("v%0d_rdy", i), ready, vecs[i].rdy);
        end

        // reset after bit 3 of AA with 33 buffered
        load = 1'b1; data_in = 8'hAA; len_in = 4'd8;
        step();
        chk("ab_b1", x_out, 1'b1);
        data_in = 8'h33;
        step();
        chk("ab_b2", x_out, 1'b0);
        chk("ab_rdy0", ready, 1'b0);
        load = 1'b0;
        step();
        chk("ab_b3", x_out, 1'b1);
        #2;
        reset = 1'b1;
        #1;
        chk("ab_xv", x_valid, 1'b0);
        chk("ab_xo", x_out, 1'b0);
        chk("ab_dn", done, 1'b0);
        chk("ab_rdy", ready, 1'b1);
        step();
        step();
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            chk($sformatf("ab_quiet%0d", i), x_valid, 1'b0);
            chk($sformatf("ab_quiet_rdy%0d", i), ready, 1'b1);
        end

        // 0B/4 -> 1,0,1,1 into the 1011 detector
        begin
            logic [5:0] exp_xo;
            logic [5:0] exp_det;
            exp_xo  = 6'b101100;
            exp_det = 6'b000010;
            load = 1'b1; data_in = 8'h0B; len_in = 4'd4;
            for (int i = 0; i < 6; i++) begin
                step();
                load = 1'b0;
                chk($sformatf("det_xo%0d", i), x_out, exp_xo[5-i]);
                chk($sformatf("det_hit%0d", i), det, exp_det[5-i]);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
